// File: rtl/pwm_gate_protect.sv
// Gate-drive protection stage: passes carrier PWM through in RUN, forces safe levels otherwise,
// and latches a trip on a filtered external fault or an A/B shoot-through overlap.
module pwm_gate_protect #(
  parameter int PWM_WIDTH      = 8,
  parameter int FLT_FILT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_onoff,
  input  logic [PWM_WIDTH-1:0]      pwmin_A_x,
  input  logic [PWM_WIDTH-1:0]      pwmin_B_x,
  input  logic [PWM_WIDTH-1:0]      safe_A_x,
  input  logic [PWM_WIDTH-1:0]      safe_B_x,
  input  logic                      fault_n,
  input  logic [FLT_FILT_WIDTH-1:0] fltfilt_count,
  input  logic                      st_detect_onoff,
  input  logic                      trip_clear,
  output logic [PWM_WIDTH-1:0]      pwmout_A_x,
  output logic [PWM_WIDTH-1:0]      pwmout_B_x,
  output logic                      trip,
  output logic [1:0]                trip_cause,
  output logic [PWM_WIDTH-1:0]      st_chan,
  output logic                      interrupt
);

  typedef enum logic [1:0] {IDLE, RUN, TRIP} state_t;

  state_t                    state;
  state_t                    next_state;
  logic                      fault_meta;
  logic                      sync_fault;
  logic [FLT_FILT_WIDTH-1:0] filt_cnt;
  logic [FLT_FILT_WIDTH-1:0] filt_thresh;
  logic                      fault_filt;
  logic [PWM_WIDTH-1:0]      overlap;
  logic                      st_hit;
  logic                      started;
  logic                      trip_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_meta <= 1'b0;
      sync_fault <= 1'b0;
    end else begin
      fault_meta <= ~fault_n;
      sync_fault <= fault_meta;
    end
  end

  // Counts consecutive synchronised fault cycles; any clean cycle restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt <= '0;
    end else if (!sync_fault) begin
      filt_cnt <= '0;
    end else if (filt_cnt != '1) begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign filt_thresh = fltfilt_count | FLT_FILT_WIDTH'(fltfilt_count == '0);
  assign fault_filt  = (filt_cnt >= filt_thresh);
  assign overlap     = pwmin_A_x & pwmin_B_x;
  assign st_hit      = st_detect_onoff & (|overlap);

  // The first edge after reset is held in IDLE so the outputs always start from safe levels.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (fault_filt)
          next_state = TRIP;
        else if (pwm_onoff && started)
          next_state = RUN;
      end
      RUN: begin
        if (fault_filt || st_hit)
          next_state = TRIP;
        else if (!pwm_onoff)
          next_state = IDLE;
      end
      TRIP: begin
        if (trip_clear && !fault_filt)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign trip_entry = (next_state == TRIP) && (state != TRIP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      started    <= 1'b0;
      pwmout_A_x <= '0;
      pwmout_B_x <= '0;
      trip       <= 1'b0;
      trip_cause <= 2'b00;
      st_chan    <= '0;
      interrupt  <= 1'b0;
    end else begin
      state     <= next_state;
      started   <= 1'b1;
      trip      <= (next_state == TRIP);
      interrupt <= trip_entry;
      if (next_state == RUN) begin
        pwmout_A_x <= pwmin_A_x;
        pwmout_B_x <= pwmin_B_x;
      end else begin
        pwmout_A_x <= safe_A_x;
        pwmout_B_x <= safe_B_x;
      end
      if (trip_entry) begin
        trip_cause <= {st_hit && (state == RUN), fault_filt};
        st_chan    <= overlap;
      end else if ((state == TRIP) && (next_state == IDLE)) begin
        trip_cause <= 2'b00;
        st_chan    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gate_protect.sv
// Self-checking bench for pwm_gate_protect: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the protection rules.
module tb_pwm_gate_protect;

  localparam int PW = 8;
  localparam int FW = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRIP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pwm_onoff = 1'b0;
  logic [PW-1:0] pwmin_A_x = '0;
  logic [PW-1:0] pwmin_B_x = '0;
  logic [PW-1:0] safe_A_x = '0;
  logic [PW-1:0] safe_B_x = '0;
  logic          fault_n = 1'b1;
  logic [FW-1:0] fltfilt_count = 8'd3;
  logic          st_detect_onoff = 1'b1;
  logic          trip_clear = 1'b0;
  logic [PW-1:0] pwmout_A_x;
  logic [PW-1:0] pwmout_B_x;
  logic          trip;
  logic [1:0]    trip_cause;
  logic [PW-1:0] st_chan;
  logic          interrupt;

  int n_checks = 0;
  int n_pass   = 0;

  int            m_state;
  bit            m_started;
  int            m_run;
  bit            m_fq[$];
  logic [PW-1:0] m_a, m_b, m_st;
  logic          m_trip, m_irq;
  logic [1:0]    m_cause;

  pwm_gate_protect #(.PWM_WIDTH(PW), .FLT_FILT_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff),
    .pwmin_A_x(pwmin_A_x), .pwmin_B_x(pwmin_B_x),
    .safe_A_x(safe_A_x), .safe_B_x(safe_B_x),
    .fault_n(fault_n), .fltfilt_count(fltfilt_count),
    .st_detect_onoff(st_detect_onoff), .trip_clear(trip_clear),
    .pwmout_A_x(pwmout_A_x), .pwmout_B_x(pwmout_B_x),
    .trip(trip), .trip_cause(trip_cause), .st_chan(st_chan), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  wire [27:0] obs_vec = {pwmout_A_x, pwmout_B_x, trip, trip_cause, st_chan, interrupt};

  function automatic logic [27:0] exp_vec();
    return {m_a, m_b, m_trip, m_cause, m_st, m_irq};
  endfunction

  task automatic model_reset();
    m_state   = M_IDLE;
    m_started = 1'b0;
    m_run     = 0;
    m_fq.delete();
    m_a = '0; m_b = '0; m_st = '0;
    m_trip = 1'b0; m_irq = 1'b0; m_cause = 2'b00;
  endtask

  // Behavioural view of one clock edge: fault seen two edges late, run-length filter, state rules.
  task automatic model_edge();
    int thr;
    int nxt;
    bit ff, hit, d;
    if (reset !== 1'b1) return;
    thr = (fltfilt_count == 0) ? 1 : int'(fltfilt_count);
    ff  = (m_run >= thr);
    hit = st_detect_onoff && ((pwmin_A_x & pwmin_B_x) != '0);
    if (m_state == M_IDLE)
      nxt = ff ? M_TRIP : ((pwm_onoff && m_started) ? M_RUN : M_IDLE);
    else if (m_state == M_RUN)
      nxt = (ff || hit) ? M_TRIP : (pwm_onoff ? M_RUN : M_IDLE);
    else
      nxt = (trip_clear && !ff) ? M_IDLE : M_TRIP;
    m_a    = (nxt == M_RUN) ? pwmin_A_x : safe_A_x;
    m_b    = (nxt == M_RUN) ? pwmin_B_x : safe_B_x;
    m_trip = (nxt == M_TRIP);
    m_irq  = (nxt == M_TRIP) && (m_state != M_TRIP);
    if (m_irq) begin
      m_cause = {hit && (m_state == M_RUN), ff};
      m_st    = pwmin_A_x & pwmin_B_x;
    end else if (m_state == M_TRIP && nxt == M_IDLE) begin
      m_cause = 2'b00;
      m_st    = '0;
    end
    d = (m_fq.size() == 2) ? m_fq[0] : 1'b0;
    m_fq.push_back(!fault_n);
    if (m_fq.size() > 2) void'(m_fq.pop_front());
    if (d) m_run = (m_run < 255) ? m_run + 1 : m_run;
    else   m_run = 0;
    m_state   = nxt;
    m_started = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    pwm_onoff = 1'b1;
    pwmin_A_x = 8'h55; pwmin_B_x = 8'hAA;
    safe_A_x  = 8'h0F; safe_B_x  = 8'hF0;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec !== 28'd0) $display("FAIL reset_outputs: got %h expected %h", obs_vec, 28'd0);
    else n_pass++;
    cycle();
    reset = 1'b1;
    cycle();
    n_checks++;
    if (pwmout_A_x !== 8'h0F || pwmout_B_x !== 8'hF0 || trip !== 1'b0)
      $display("FAIL reset_first_edge_safe: got %h/%h trip %b expected 0f/f0 trip 0", pwmout_A_x, pwmout_B_x, trip);
    else n_pass++;
    cycle();
    n_checks++;
    if (pwmout_A_x !== 8'h55 || pwmout_B_x !== 8'hAA || trip !== 1'b0)
      $display("FAIL reset_then_run: got %h/%h trip %b expected 55/aa trip 0", pwmout_A_x, pwmout_B_x, trip);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    pwmin_A_x = 8'h55; pwmin_B_x = 8'hAA;
    cycle();
    n_checks++;
    if (pwmout_A_x !== 8'h55 || pwmout_B_x !== 8'hAA || trip !== 1'b0)
      $display("FAIL passthrough_55aa: got %h/%h trip %b expected 55/aa trip 0", pwmout_A_x, pwmout_B_x, trip);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      pwmin_A_x = PW'($urandom);
      pwmin_B_x = PW'($urandom) & ~pwmin_A_x;
      safe_A_x  = PW'($urandom);
      safe_B_x  = PW'($urandom);
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL passthrough_rand: got %h expected %h", obs_vec, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_shoot_through();
    safe_A_x = 8'h11; safe_B_x = 8'h22;
    pwmin_A_x = 8'h04; pwmin_B_x = 8'h04;
    cycle();
    n_checks++;
    if (pwmout_A_x !== 8'h11 || pwmout_B_x !== 8'h22 || trip !== 1'b1 || trip_cause !== 2'b10 ||
        st_chan !== 8'h04 || interrupt !== 1'b1)
      $display("FAIL shoot_through_entry: got %h expected %h", obs_vec,
               {8'h11, 8'h22, 1'b1, 2'b10, 8'h04, 1'b1});
    else n_pass++;
    pwmin_A_x = 8'h55; pwmin_B_x = 8'hAA;
    cycle();
    n_checks++;
    if (interrupt !== 1'b0 || trip !== 1'b1 || trip_cause !== 2'b10 || st_chan !== 8'h04 || pwmout_A_x !== 8'h11)
      $display("FAIL shoot_through_hold: got %h expected %h", obs_vec,
               {8'h11, 8'h22, 1'b1, 2'b10, 8'h04, 1'b0});
    else n_pass++;
    trip_clear = 1'b1;
    cycle();
    trip_clear = 1'b0;
    n_checks++;
    if (trip !== 1'b0 || trip_cause !== 2'b00 || st_chan !== 8'h00 || obs_vec !== exp_vec())
      $display("FAIL shoot_through_clear: got %h expected %h", obs_vec, exp_vec());
    else n_pass++;
    cycle();
  endtask

  task automatic test_fault_filter();
    fltfilt_count = 8'd5;
    fault_n = 1'b0;
    repeat (4) cycle();
    fault_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (trip !== 1'b0 || obs_vec !== exp_vec())
        $display("FAIL filter_short_glitch: got %h expected %h", obs_vec, exp_vec());
      else n_pass++;
    end
    fault_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_checks++;
      if ((k < 8 && trip !== 1'b0) ||
          (k == 8 && (trip !== 1'b1 || trip_cause !== 2'b01 || interrupt !== 1'b1 ||
                      pwmout_A_x !== safe_A_x || pwmout_B_x !== safe_B_x)))
        $display("FAIL filter_trip_edge%0d: got %h expected trip %b", k, obs_vec, k == 8);
      else n_pass++;
    end
  endtask

  task automatic test_trip_clear();
    trip_clear = 1'b1;
    repeat (2) begin
      cycle();
      n_checks++;
      if (trip !== 1'b1 || trip_cause !== 2'b01)
        $display("FAIL clear_ignored_while_fault: got trip %b cause %b expected 1 01", trip, trip_cause);
      else n_pass++;
    end
    trip_clear = 1'b0;
    fault_n = 1'b1;
    repeat (4) cycle();
    trip_clear = 1'b1;
    cycle();
    trip_clear = 1'b0;
    n_checks++;
    if (trip !== 1'b0 || trip_cause !== 2'b00 || pwmout_A_x !== safe_A_x)
      $display("FAIL clear_to_idle: got %h expected %h", obs_vec, exp_vec());
    else n_pass++;
    cycle();
    n_checks++;
    if (pwmout_A_x !== pwmin_A_x || pwmout_B_x !== pwmin_B_x || trip !== 1'b0)
      $display("FAIL clear_then_run: got %h/%h expected %h/%h", pwmout_A_x, pwmout_B_x, pwmin_A_x, pwmin_B_x);
    else n_pass++;
  endtask

  task automatic test_both_causes();
    fltfilt_count = 8'd1;
    fault_n = 1'b0;
    repeat (3) cycle();
    pwmin_A_x = 8'h30; pwmin_B_x = 8'h10;
    cycle();
    n_checks++;
    if (trip !== 1'b1 || trip_cause !== 2'b11 || st_chan !== 8'h10 || interrupt !== 1'b1)
      $display("FAIL both_causes: got trip %b cause %b st %h irq %b expected 1 11 10 1",
               trip, trip_cause, st_chan, interrupt);
    else n_pass++;
    pwmin_A_x = 8'h55; pwmin_B_x = 8'hAA;
    fault_n = 1'b1;
    repeat (4) cycle();
    trip_clear = 1'b1;
    cycle();
    trip_clear = 1'b0;
    cycle();
    pwm_onoff = 1'b0;
    cycle();
    n_checks++;
    if (pwmout_A_x !== safe_A_x || pwmout_B_x !== safe_B_x || trip !== 1'b0 || obs_vec !== exp_vec())
      $display("FAIL onoff_to_idle: got %h expected %h", obs_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pwm_onoff       = ($urandom_range(0, 9) != 0);
      pwmin_A_x       = PW'($urandom);
      pwmin_B_x       = ($urandom_range(0, 19) == 0) ? PW'($urandom) : (PW'($urandom) & ~pwmin_A_x);
      safe_A_x        = PW'($urandom);
      safe_B_x        = PW'($urandom);
      fault_n         = ($urandom_range(0, 5) != 0);
      fltfilt_count   = FW'($urandom_range(0, 3));
      st_detect_onoff = ($urandom_range(0, 7) != 0);
      trip_clear      = ($urandom_range(0, 4) == 0);
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec, exp_vec());
      else n_pass++;
    end
    trip_clear = 1'b0; fault_n = 1'b1; st_detect_onoff = 1'b1;
  endtask

  task automatic test_reset_in_trip();
    reset = 1'b0;
    model_reset();
    cycle();
    reset = 1'b1;
    pwm_onoff = 1'b1;
    pwmin_A_x = 8'h01; pwmin_B_x = 8'h02;
    repeat (2) cycle();
    pwmin_A_x = 8'h81; pwmin_B_x = 8'h80;
    cycle();
    n_checks++;
    if (trip !== 1'b1 || st_chan !== 8'h80 || trip_cause !== 2'b10)
      $display("FAIL pre_reset_trip: got trip %b st %h cause %b expected 1 80 10", trip, st_chan, trip_cause);
    else n_pass++;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec !== 28'd0) $display("FAIL async_reset_in_trip: got %h expected %h", obs_vec, 28'd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_shoot_through();
    test_fault_filter();
    test_trip_clear();
    test_both_causes();
    test_random();
    test_reset_in_trip();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
